bm_freeb_ctrl: RTL and testbench
================================

BM_FREEB_CTRL -- requirements
Module: bm_freeb_ctrl

Interface
REQ-001 Parameter BUF_NBITS, default `BUF_PTR_NBITS; buffer pointer width.
REQ-002 Parameter NUM_BUF, default 1<<BUF_NBITS; number of buffers managed, 2..2^BUF_NBITS.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 `RESET_SIG  in  1  synchronous, active-low reset.
REQ-005 freeb_init  in  1  level from register block; a rising edge starts list initialisation.
REQ-006 freeb_init_done  out  1  free list initialised and in service.
REQ-007 alloc_req  in  1  allocate-buffer request; held until alloc_ack.
REQ-008 alloc_ack  out  1  one-cycle pulse; alloc_ptr valid.
REQ-009 alloc_ptr  out  BUF_NBITS  allocated buffer pointer.
REQ-010 rel_req[1:0]  in  2  release requests from two clients; each held until its rel_ack.
REQ-011 rel_ptr0, rel_ptr1  in  BUF_NBITS each  pointers being returned.
REQ-012 rel_ack[1:0]  out  2  one-cycle pulse per client; release accepted.
REQ-013 ram_rd, ram_wr  out  1 each  free-list RAM strobes, mutually exclusive.
REQ-014 ram_addr  out  BUF_NBITS  free-list RAM address.
REQ-015 ram_wdata  out  BUF_NBITS  RAM write data.
REQ-016 ram_rdata  in  BUF_NBITS  RAM read data, valid the cycle after ram_rd.
REQ-017 inc_freeb_rd_count, inc_freeb_wr_count  out  1 each  one-cycle pulses to the register-block counters.
REQ-018 free_count  out  BUF_NBITS+1  buffers currently in the free list.
REQ-019 ovf_err  out  1  sticky; release attempted while the list was full.

Function
REQ-020 States: IDLE, INIT, RUN; reset enters IDLE.
REQ-021 IDLE->INIT on a freeb_init rising edge (freeb_init=1 and its registered copy=0); RUN->INIT on the same condition.
REQ-022 On INIT entry: freeb_init_done=0, head=0, tail=0, free_count=0, and all pending operations discarded.
REQ-023 INIT writes one entry per cycle (ram_wr=1, ram_addr=ram_wdata=i) for i=0..NUM_BUF-1, NUM_BUF cycles total; no RAM reads.
REQ-024 INIT writes do not pulse inc_freeb_wr_count.
REQ-025 After the last INIT write: next state RUN, head=0, tail=NUM_BUF mod 2^BUF_NBITS, free_count=NUM_BUF, freeb_init_done=1.
REQ-026 Requests are neither granted nor acked in IDLE or INIT.
REQ-027 In RUN, at most one of {alloc, rel0, rel1} is granted per cycle, selected round-robin.
REQ-028 Round-robin pointer advances to the entry after the winner; reset value favours alloc, then rel0, then rel1.
REQ-029 alloc is eligible only when alloc_req=1, free_count>0, and no alloc is awaiting its ack.
REQ-030 Alloc grant in cycle N: ram_rd=1, ram_addr=head, head+1 (wraps at 2^BUF_NBITS), free_count-1, inc_freeb_rd_count=1.
REQ-031 Alloc response in cycle N+1: alloc_ack=1, alloc_ptr=ram_rdata; another op may be granted in N+1.
REQ-032 Release grant for client k: ram_wr=1, ram_addr=tail, ram_wdata=rel_ptrk, tail+1 (wraps), free_count+1, inc_freeb_wr_count=1, rel_ack[k]=1, all in the same cycle.
REQ-033 Release with free_count==NUM_BUF: rel_ack[k]=1, no RAM write, no count or pointer change, no inc pulse, ovf_err set to 1.
REQ-034 free_count never exceeds NUM_BUF and never underflows.
REQ-035 ovf_err clears only on reset or INIT entry.
REQ-036 alloc_ptr holds its last value between acks; outputs not otherwise specified are 0 when inactive.

Reset
REQ-037 Reset in any state, including mid-INIT or with an alloc response pending, gives: state IDLE; freeb_init_done=0; alloc_ack=0; rel_ack=0; ram_rd=0; ram_wr=0; inc pulses 0; alloc_ptr=0; ram_addr=0; ram_wdata=0; free_count=0; head=tail=0; ovf_err=0; rr pointer=alloc; freeb_init registered copy=0.
REQ-038 Pending requests are not acked after reset until a new INIT completes.

Verification
REQ-039 NUM_BUF=8, rising freeb_init -> 8 consecutive writes addr/data 0..7, then freeb_init_done=1, free_count=8.
REQ-040 After init, alloc_req held for 3 allocs -> alloc_ptr 0,1,2 each one cycle after its ram_rd; free_count=5; three inc_freeb_rd_count pulses.
REQ-041 alloc, rel0, rel1 requested together continuously -> grants rotate alloc, rel0, rel1, alloc…; no RAM read and write in the same cycle.
REQ-042 free_count=0 with alloc_req and rel0 (ptr 5) both asserted -> rel0 granted first; next cycle alloc granted, alloc_ptr=5.
REQ-043 free_count=8, rel1 asserted -> rel_ack[1]=1, no ram_wr, ovf_err=1, count stays 8.
REQ-044 Reset asserted at INIT cycle 3 -> all REQ-037 values next cycle; freeb_init re-toggled -> full 8-cycle INIT restarts from address 0.

Source files
------------

// File: rtl/bm_freeb_ctrl.sv
// Free-buffer list controller: initialises a RAM-backed FIFO of buffer pointers, then
// serves allocations and two release clients with round-robin arbitration.
`ifndef BUF_PTR_NBITS
`define BUF_PTR_NBITS 3
`endif

module bm_freeb_ctrl #(
  parameter int BUF_NBITS = `BUF_PTR_NBITS,
  parameter int NUM_BUF   = 1 << BUF_NBITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 freeb_init,
  output logic                 freeb_init_done,
  input  logic                 alloc_req,
  output logic                 alloc_ack,
  output logic [BUF_NBITS-1:0] alloc_ptr,
  input  logic [1:0]           rel_req,
  input  logic [BUF_NBITS-1:0] rel_ptr0,
  input  logic [BUF_NBITS-1:0] rel_ptr1,
  output logic [1:0]           rel_ack,
  output logic                 ram_rd,
  output logic                 ram_wr,
  output logic [BUF_NBITS-1:0] ram_addr,
  output logic [BUF_NBITS-1:0] ram_wdata,
  input  logic [BUF_NBITS-1:0] ram_rdata,
  output logic                 inc_freeb_rd_count,
  output logic                 inc_freeb_wr_count,
  output logic [BUF_NBITS:0]   free_count,
  output logic                 ovf_err
);

  localparam int CW = BUF_NBITS + 1;
  localparam logic [CW-1:0]        NUM_BUF_C = CW'(NUM_BUF);
  localparam logic [BUF_NBITS-1:0] LAST_IDX  = BUF_NBITS'(NUM_BUF - 1);
  localparam logic [BUF_NBITS-1:0] TAIL_INIT = BUF_NBITS'(NUM_BUF);
  localparam logic [1:0] RR_ALLOC = 2'd0;
  localparam logic [1:0] RR_REL0  = 2'd1;
  localparam logic [1:0] RR_REL1  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_INIT = 2'd1, ST_RUN = 2'd2} state_e;

  state_e               state_q, state_d;
  logic                 freeb_init_q, freeb_init_d;
  logic                 freeb_init_done_q, freeb_init_done_d;
  logic [BUF_NBITS-1:0] head_q, head_d, tail_q, tail_d, init_idx_q, init_idx_d;
  logic [CW-1:0]        free_count_q, free_count_d;
  logic                 ovf_err_q, ovf_err_d;
  logic [1:0]           rr_q, rr_d;
  logic                 alloc_ack_q, alloc_ack_d;
  logic [BUF_NBITS-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [1:0]           rel_ack_q, rel_ack_d;
  logic                 ram_rd_q, ram_rd_d, ram_wr_q, ram_wr_d;
  logic [BUF_NBITS-1:0] ram_addr_q, ram_addr_d, ram_wdata_q, ram_wdata_d;
  logic                 inc_rd_q, inc_rd_d, inc_wr_q, inc_wr_d;

  logic                 init_rise_s, enter_init_s;
  logic                 elig_alloc_s, elig_rel0_s, elig_rel1_s;
  logic [2:0]           pick_s;
  logic [BUF_NBITS-1:0] rel_ptr_s;

  // Returns {valid, winner}, searching from start in the order alloc, rel0, rel1.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] start);
    logic [2:0] s;
    rr_pick = 3'b000;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, start} + 3'(i);
      if (s >= 3'd3) s = s - 3'd3;
      if (!rr_pick[2] && req[s[1:0]]) rr_pick = {1'b1, s[1:0]};
    end
  endfunction

  // An op is ineligible while its own ack is still in flight, since the client still holds req.
  assign init_rise_s  = freeb_init & ~freeb_init_q;
  assign elig_alloc_s = alloc_req && (free_count_q != CW'(0)) && !ram_rd_q && !alloc_ack_q;
  assign elig_rel0_s  = rel_req[0] && !rel_ack_q[0];
  assign elig_rel1_s  = rel_req[1] && !rel_ack_q[1];
  assign pick_s       = rr_pick({elig_rel1_s, elig_rel0_s, elig_alloc_s}, rr_q);
  assign rel_ptr_s    = (pick_s[1:0] == RR_REL1) ? rel_ptr1 : rel_ptr0;

  // Next-state and registered-output computation.
  always_comb begin
    state_d           = state_q;
    freeb_init_d      = freeb_init;
    freeb_init_done_d = freeb_init_done_q;
    head_d            = head_q;
    tail_d            = tail_q;
    init_idx_d        = init_idx_q;
    free_count_d      = free_count_q;
    ovf_err_d         = ovf_err_q;
    rr_d              = rr_q;
    alloc_ack_d       = 1'b0;
    alloc_ptr_d       = alloc_ack_q ? ram_rdata : alloc_ptr_q;
    rel_ack_d         = 2'b00;
    ram_rd_d          = 1'b0;
    ram_wr_d          = 1'b0;
    ram_addr_d        = '0;
    ram_wdata_d       = '0;
    inc_rd_d          = 1'b0;
    inc_wr_d          = 1'b0;
    enter_init_s      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init_rise_s) enter_init_s = 1'b1;
        else             state_d = ST_IDLE;
      end
      ST_INIT: begin
        ram_wr_d    = 1'b1;
        ram_addr_d  = init_idx_q;
        ram_wdata_d = init_idx_q;
        if (init_idx_q == LAST_IDX) begin
          state_d           = ST_RUN;
          head_d            = '0;
          tail_d            = TAIL_INIT;
          free_count_d      = NUM_BUF_C;
          freeb_init_done_d = 1'b1;
        end else begin
          init_idx_d = init_idx_q + BUF_NBITS'(1);
        end
      end
      ST_RUN: begin
        if (init_rise_s) begin
          enter_init_s = 1'b1;
        end else begin
          alloc_ack_d = ram_rd_q;
          if (pick_s[2]) begin
            rr_d = (pick_s[1:0] == RR_REL1) ? RR_ALLOC : pick_s[1:0] + 2'd1;
            if (pick_s[1:0] == RR_ALLOC) begin
              ram_rd_d     = 1'b1;
              ram_addr_d   = head_q;
              head_d       = head_q + BUF_NBITS'(1);
              free_count_d = free_count_q - CW'(1);
              inc_rd_d     = 1'b1;
            end else begin
              rel_ack_d = (pick_s[1:0] == RR_REL0) ? 2'b01 : 2'b10;
              if (free_count_q == NUM_BUF_C) begin
                ovf_err_d = 1'b1;
              end else begin
                ram_wr_d     = 1'b1;
                ram_addr_d   = tail_q;
                ram_wdata_d  = rel_ptr_s;
                tail_d       = tail_q + BUF_NBITS'(1);
                free_count_d = free_count_q + CW'(1);
                inc_wr_d     = 1'b1;
              end
            end
          end else begin
            rr_d = rr_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Entering INIT drops any operation in flight, including a pending alloc response.
    if (enter_init_s) begin
      state_d           = ST_INIT;
      init_idx_d        = '0;
      head_d            = '0;
      tail_d            = '0;
      free_count_d      = '0;
      ovf_err_d         = 1'b0;
      freeb_init_done_d = 1'b0;
      alloc_ack_d       = 1'b0;
    end else begin
      init_idx_d = init_idx_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      freeb_init_q      <= 1'b0;
      freeb_init_done_q <= 1'b0;
      head_q            <= '0;
      tail_q            <= '0;
      init_idx_q        <= '0;
      free_count_q      <= '0;
      ovf_err_q         <= 1'b0;
      rr_q              <= RR_ALLOC;
      alloc_ack_q       <= 1'b0;
      alloc_ptr_q       <= '0;
      rel_ack_q         <= 2'b00;
      ram_rd_q          <= 1'b0;
      ram_wr_q          <= 1'b0;
      ram_addr_q        <= '0;
      ram_wdata_q       <= '0;
      inc_rd_q          <= 1'b0;
      inc_wr_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      freeb_init_q      <= freeb_init_d;
      freeb_init_done_q <= freeb_init_done_d;
      head_q            <= head_d;
      tail_q            <= tail_d;
      init_idx_q        <= init_idx_d;
      free_count_q      <= free_count_d;
      ovf_err_q         <= ovf_err_d;
      rr_q              <= rr_d;
      alloc_ack_q       <= alloc_ack_d;
      alloc_ptr_q       <= alloc_ptr_d;
      rel_ack_q         <= rel_ack_d;
      ram_rd_q          <= ram_rd_d;
      ram_wr_q          <= ram_wr_d;
      ram_addr_q        <= ram_addr_d;
      ram_wdata_q       <= ram_wdata_d;
      inc_rd_q          <= inc_rd_d;
      inc_wr_q          <= inc_wr_d;
    end
  end

  // Read data arrives the cycle after ram_rd, so the pointer is passed through during the ack.
  assign alloc_ptr          = alloc_ack_q ? ram_rdata : alloc_ptr_q;
  assign freeb_init_done    = freeb_init_done_q;
  assign alloc_ack          = alloc_ack_q;
  assign rel_ack            = rel_ack_q;
  assign ram_rd             = ram_rd_q;
  assign ram_wr             = ram_wr_q;
  assign ram_addr           = ram_addr_q;
  assign ram_wdata          = ram_wdata_q;
  assign inc_freeb_rd_count = inc_rd_q;
  assign inc_freeb_wr_count = inc_wr_q;
  assign free_count         = free_count_q;
  assign ovf_err            = ovf_err_q;

endmodule

// File: tb/tb_bm_freeb_ctrl.sv
// Directed self-checking bench for bm_freeb_ctrl with NUM_BUF=8 and a behavioural free-list RAM.
module tb_bm_freeb_ctrl;

  localparam int BN = 3;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          freeb_init;
  logic          freeb_init_done;
  logic          alloc_req;
  logic          alloc_ack;
  logic [BN-1:0] alloc_ptr;
  logic [1:0]    rel_req;
  logic [BN-1:0] rel_ptr0, rel_ptr1;
  logic [1:0]    rel_ack;
  logic          ram_rd, ram_wr;
  logic [BN-1:0] ram_addr, ram_wdata;
  logic [BN-1:0] ram_rdata = '0;
  logic          inc_freeb_rd_count, inc_freeb_wr_count;
  logic [BN:0]   free_count;
  logic          ovf_err;

  logic [BN-1:0] mem [0:NB-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bm_freeb_ctrl #(.BUF_NBITS(BN), .NUM_BUF(NB)) dut (
    .clk(clk), .rst_n(rst_n), .freeb_init(freeb_init), .freeb_init_done(freeb_init_done),
    .alloc_req(alloc_req), .alloc_ack(alloc_ack), .alloc_ptr(alloc_ptr),
    .rel_req(rel_req), .rel_ptr0(rel_ptr0), .rel_ptr1(rel_ptr1), .rel_ack(rel_ack),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .inc_freeb_rd_count(inc_freeb_rd_count),
    .inc_freeb_wr_count(inc_freeb_wr_count), .free_count(free_count), .ovf_err(ovf_err)
  );

  // Free-list RAM: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr] <= ram_wdata;
    if (ram_rd) ram_rdata <= mem[ram_addr];
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(output int ptr);
    int seen;
    seen = 0;
    ptr = -1;
    alloc_req = 1'b1;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      step();
      if (alloc_ack) begin
        ptr  = alloc_ptr;
        seen = 1;
      end
    end
    alloc_req = 1'b0;
    check_val("alloc_acked", seen, 1);
  endtask

  task automatic do_rel(input int k, input int ptr, output int wr, output int inc,
                        output int addr, output int wdata);
    int seen;
    seen = 0;
    wr = -1; inc = -1; addr = -1; wdata = -1;
    if (k == 0) rel_ptr0 = BN'(ptr); else rel_ptr1 = BN'(ptr);
    rel_req[k] = 1'b1;
    for (int i = 0; i < 12 && seen == 0; i++) begin
      step();
      if (rel_ack[k]) begin
        seen = 1; wr = ram_wr; inc = inc_freeb_wr_count; addr = ram_addr; wdata = ram_wdata;
      end
    end
    rel_req[k] = 1'b0;
    check_val("rel_acked", seen, 1);
  endtask

  task automatic run_init(input string tag);
    step();
    check_val({tag, "_entry_wr"}, ram_wr, 0);
    check_val({tag, "_entry_done"}, freeb_init_done, 0);
    for (int i = 0; i < NB; i++) begin
      step();
      check_val({tag, "_wr"}, ram_wr, 1);
      check_val({tag, "_rd"}, ram_rd, 0);
      check_val({tag, "_addr"}, ram_addr, i);
      check_val({tag, "_wdata"}, ram_wdata, i);
      check_val({tag, "_incwr"}, inc_freeb_wr_count, 0);
    end
    check_val({tag, "_done"}, freeb_init_done, 1);
    check_val({tag, "_count"}, free_count, NB);
  endtask

  int nrd, nack, ninc, rd_cyc, ng, g, p, wr, inc, addr, wdata;
  int rot_exp [6] = '{1, 2, 0, 1, 2, 0};
  int drain_exp [8] = '{5, 6, 7, 0, 1, 0, 1, 2};

  initial begin
    rst_n = 1'b0; freeb_init = 1'b0; alloc_req = 1'b0; rel_req = 2'b00;
    rel_ptr0 = '0; rel_ptr1 = '0;
    step(); step();
    check_val("rst_done", freeb_init_done, 0);
    check_val("rst_count", free_count, 0);
    check_val("rst_wr", ram_wr, 0);
    check_val("rst_ovf", ovf_err, 0);
    rst_n = 1'b1;
    step();
    check_val("idle_wr", ram_wr, 0);

    // Rising freeb_init: eight consecutive initialising writes.
    freeb_init = 1'b1;
    run_init("init");

    // Three allocations: pointers 0,1,2 each one cycle after its read.
    alloc_req = 1'b1; nrd = 0; nack = 0; ninc = 0; rd_cyc = 0;
    for (int cyc = 0; cyc < 24 && nack < 3; cyc++) begin
      step();
      if (ram_rd) begin
        check_val("a3_addr", ram_addr, nrd);
        rd_cyc = cyc; nrd++;
        if (nrd == 3) alloc_req = 1'b0;
      end
      if (inc_freeb_rd_count) ninc++;
      if (alloc_ack) begin
        check_val("a3_ptr", alloc_ptr, nack);
        check_val("a3_lat", cyc - rd_cyc, 1);
        nack++;
      end
    end
    check_val("a3_acks", nack, 3);
    check_val("a3_inc", ninc, 3);
    check_val("a3_count", free_count, 5);

    // All three requesting: rotation continues after alloc, so rel0 leads.
    alloc_req = 1'b1; rel_req = 2'b11; rel_ptr0 = 3'd0; rel_ptr1 = 3'd1; ng = 0;
    for (int cyc = 0; cyc < 30 && ng < 6; cyc++) begin
      step();
      check_val("rot_rdwr", int'(ram_rd && ram_wr), 0);
      g = -1;
      if (ram_rd) g = 0;
      else if (rel_ack[0]) g = 1;
      else if (rel_ack[1]) g = 2;
      else g = -1;
      if (g >= 0) begin
        check_val("rot_seq", g, rot_exp[ng]);
        ng++;
        if (ng == 6) begin alloc_req = 1'b0; rel_req = 2'b00; end
      end
    end
    check_val("rot_grants", ng, 6);
    check_val("rot_count", free_count, 7);

    // Fill to eight, then a release into a full list overflows.
    do_rel(0, 2, wr, inc, addr, wdata);
    check_val("rel_wr", wr, 1);
    check_val("rel_addr", addr, 4);
    check_val("rel_wdata", wdata, 2);
    check_val("rel_inc", inc, 1);
    check_val("rel_count", free_count, 8);
    check_val("pre_ovf", ovf_err, 0);
    do_rel(1, 3, wr, inc, addr, wdata);
    check_val("ovf_wr", wr, 0);
    check_val("ovf_inc", inc, 0);
    check_val("ovf_flag", ovf_err, 1);
    check_val("ovf_count", free_count, 8);

    // Drain to empty.
    for (int i = 0; i < NB; i++) begin
      do_alloc(p);
      check_val("drain_ptr", p, drain_exp[i]);
    end
    check_val("drain_count", free_count, 0);
    check_val("ovf_sticky", ovf_err, 1);

    // Empty list: release must win, then the alloc returns that pointer.
    alloc_req = 1'b1; rel_req = 2'b01; rel_ptr0 = 3'd5;
    step();
    check_val("e_relack", rel_ack, 1);
    check_val("e_rd0", ram_rd, 0);
    check_val("e_wraddr", ram_addr, 5);
    rel_req = 2'b00;
    step();
    check_val("e_rd1", ram_rd, 1);
    check_val("e_rdaddr", ram_addr, 5);
    step();
    check_val("e_ack", alloc_ack, 1);
    check_val("e_ptr", alloc_ptr, 5);
    alloc_req = 1'b0;
    step();
    check_val("e_ack_off", alloc_ack, 0);
    check_val("e_ptr_hold", alloc_ptr, 5);

    // Re-init from RUN, reset at INIT write 3, then a full restart.
    freeb_init = 1'b0;
    step();
    freeb_init = 1'b1;
    step();
    check_val("ri_ovf", ovf_err, 0);
    check_val("ri_count", free_count, 0);
    check_val("ri_done", freeb_init_done, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("ri_addr", ram_addr, i);
    end
    rst_n = 1'b0; freeb_init = 1'b0; alloc_req = 1'b1;
    step();
    check_val("r2_wr", ram_wr, 0);
    check_val("r2_addr", ram_addr, 0);
    check_val("r2_wdata", ram_wdata, 0);
    check_val("r2_count", free_count, 0);
    check_val("r2_ptr", alloc_ptr, 0);
    check_val("r2_done", freeb_init_done, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("r2_idle_rd", ram_rd, 0);
      check_val("r2_idle_ack", alloc_ack, 0);
    end
    alloc_req = 1'b0;
    freeb_init = 1'b1;
    run_init("reinit");
    do_alloc(p);
    check_val("reinit_ptr", p, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
